mem_access_stage: RTL and testbench

- Memory stage directly downstream of the execute/memory pipeline register.
- Consumes the registered ALU address, the scalar/vector store data and the memory control flags.
- Performs byte-serial scalar or vector loads and stores against an internal byte-wide data memory, and stalls upstream while busy.
- Presents load results with a one-cycle valid pulse toward writeback.

---
 rtl/mem_access_stage.sv | 155 +++++++++++++++
 tb/tb_mem_access_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : Byte-serial scalar/vector load-store unit over an internal
//            byte-wide data memory. It stalls upstream while it is busy.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int MEMO_LINES = 64,
    parameter int REGI_SIZE  = 16,
    parameter int VECT_SIZE  = 8,
    parameter int ELEM_SIZE  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [REGI_SIZE-1:0]           ialu_res_i,
    input  logic [REGI_SIZE-1:0]           iswa_res_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] vswa_res_i,
    input  logic                           enableMem_i,
    input  logic                           flagMemRead_i,
    input  logic                           flagMemWrite_i,
    input  logic                           vecOp_i,
    output logic                           stall_o,
    output logic                           valid_o,
    output logic [REGI_SIZE-1:0]           memData_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] vmemData_o,
    output logic                           err_o
);

    localparam int ADDR_W     = $clog2(MEMO_LINES);
    localparam int VEC_W      = ELEM_SIZE * VECT_SIZE;
    localparam int SCAL_BEATS = REGI_SIZE / 8;
    localparam int MAX_BEATS  = (VECT_SIZE > SCAL_BEATS) ? VECT_SIZE : SCAL_BEATS;
    localparam int BEAT_W     = $clog2(MAX_BEATS + 1);
    localparam int DATA_W     = (VEC_W > REGI_SIZE) ? VEC_W : REGI_SIZE;

    localparam logic [BEAT_W-1:0] C_SCAL_LAST = BEAT_W'(SCAL_BEATS - 1);
    localparam logic [BEAT_W-1:0] C_VEC_LAST  = BEAT_W'(VECT_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [7:0]          r_mem [MEMO_LINES];

    logic [ADDR_W-1:0]   r_base;
    logic                r_isWrite;
    logic                r_isVec;
    logic [DATA_W-1:0]   r_wrData;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_stall;
    logic                r_valid;
    logic                r_err;
    logic [REGI_SIZE-1:0] r_memData;
    logic [VEC_W-1:0]    r_vmemData;

    logic                w_req;
    logic                w_illegal;
    logic                w_lastBeat;
    logic [ADDR_W-1:0]   w_addr;
    logic [7:0]          w_rdByte;
    logic                w_wen;
    logic                w_unused;

    assign w_req      = enableMem_i && (flagMemRead_i ^ flagMemWrite_i);
    assign w_illegal  = enableMem_i && flagMemRead_i && flagMemWrite_i;
    assign w_lastBeat = (r_beat == (r_isVec ? C_VEC_LAST : C_SCAL_LAST));
    // Address arithmetic in ADDR_W bits gives the wrap at the top of memory.
    assign w_addr     = r_base + ADDR_W'(r_beat);
    assign w_rdByte   = r_mem[w_addr];
    assign w_wen      = !rst_i && (r_state == S_ACCESS) && r_isWrite;
    assign w_unused   = &{1'b0, ialu_res_i[REGI_SIZE-1:ADDR_W]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_req)      w_nextState = S_ACCESS;
            S_ACCESS: if (w_lastBeat) w_nextState = S_DONE;
            S_DONE:                   w_nextState = S_IDLE;
            default:                  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base     <= '0;
            r_isWrite  <= 1'b0;
            r_isVec    <= 1'b0;
            r_wrData   <= '0;
            r_beat     <= '0;
            r_stall    <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_memData  <= '0;
            r_vmemData <= '0;
        end else begin
            r_stall <= (w_nextState == S_ACCESS);
            r_valid <= (w_nextState == S_DONE);
            r_err   <= (r_state == S_IDLE) && w_illegal;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_base    <= ialu_res_i[ADDR_W-1:0];
                        r_isWrite <= flagMemWrite_i;
                        r_isVec   <= vecOp_i;
                        r_wrData  <= vecOp_i ? DATA_W'(vswa_res_i) : DATA_W'(iswa_res_i);
                        r_beat    <= '0;
                    end
                end
                S_ACCESS: begin
                    // Store data and load results both move one byte per beat,
                    // little-endian, so everything is a plain byte shift.
                    r_beat   <= r_beat + BEAT_W'(1);
                    r_wrData <= r_wrData >> 8;
                    if (!r_isWrite) begin
                        if (r_isVec) begin
                            r_vmemData <= (r_vmemData >> 8) | (VEC_W'(w_rdByte) << (VEC_W - 8));
                        end else begin
                            r_memData <= (r_memData >> 8) | (REGI_SIZE'(w_rdByte) << (REGI_SIZE - 8));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory contents survive reset; only the write of the reset cycle is dropped.
    always_ff @(posedge clk_i) begin
        if (w_wen) begin
            r_mem[w_addr] <= r_wrData[7:0];
        end
    end

    assign stall_o    = r_stall;
    assign valid_o    = r_valid;
    assign err_o      = r_err;
    assign memData_o  = r_memData;
    assign vmemData_o = r_vmemData;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Directed and random load/store checks against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int ML = 64;
    localparam int RS = 16;
    localparam int VS = 8;
    localparam int ES = 8;
    localparam int VW = ES * VS;

    logic          clk = 1'b0;
    logic          rst;
    logic [RS-1:0] ialuRes;
    logic [RS-1:0] iswaRes;
    logic [VW-1:0] vswaRes;
    logic          enableMem;
    logic          flagMemRead;
    logic          flagMemWrite;
    logic          vecOp;
    logic          stall;
    logic          valid;
    logic [RS-1:0] memData;
    logic [VW-1:0] vmemData;
    logic          err;

    mem_access_stage #(
        .MEMO_LINES(ML), .REGI_SIZE(RS), .VECT_SIZE(VS), .ELEM_SIZE(ES)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ialu_res_i(ialuRes), .iswa_res_i(iswaRes),
        .vswa_res_i(vswaRes), .enableMem_i(enableMem), .flagMemRead_i(flagMemRead),
        .flagMemWrite_i(flagMemWrite), .vecOp_i(vecOp), .stall_o(stall),
        .valid_o(valid), .memData_o(memData), .vmemData_o(vmemData), .err_o(err)
    );

    always #5 clk = ~clk;

    int            nChecks = 0;
    int            nFails  = 0;
    logic [7:0]    refMem [ML];
    logic [RS-1:0] refScal;
    logic [VW-1:0] refVec;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        enableMem = 1'b0; flagMemRead = 1'b0; flagMemWrite = 1'b0; vecOp = 1'b0;
    endtask

    task automatic checkMemAll(input string tag);
        for (int i = 0; i < ML; i++) check(tag, dut.r_mem[i], refMem[i]);
    endtask

    task automatic checkOutputs(input string tag, input bit expStall, input bit expValid);
        check({tag, "_stall"}, stall, expStall);
        check({tag, "_valid"}, valid, expValid);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_memData"}, memData, refScal);
        check({tag, "_vmemData"}, vmemData, refVec);
    endtask

    // Apply the model's effect of one complete access.
    task automatic modelAccess(input bit isVec, input bit isWr, input int addr,
                               input logic [RS-1:0] sd, input logic [VW-1:0] vd);
        int n = isVec ? VS : RS / 8;
        for (int k = 0; k < n; k++) begin
            int a = (addr + k) % ML;
            if (isWr) refMem[a] = isVec ? vd[8*k +: 8] : sd[8*k +: 8];
            else if (isVec) refVec[8*k +: 8] = refMem[a];
            else refScal[8*k +: 8] = refMem[a];
        end
    endtask

    task automatic access(input bit isVec, input bit isWr, input int addr,
                          input logic [RS-1:0] sd, input logic [VW-1:0] vd);
        int n = isVec ? VS : RS / 8;
        enableMem = 1'b1; flagMemRead = !isWr; flagMemWrite = isWr; vecOp = isVec;
        ialuRes = RS'(addr); iswaRes = sd; vswaRes = vd;
        tick();
        idleInputs();
        iswaRes = RS'($urandom);
        vswaRes = {$urandom, $urandom};
        for (int k = 0; k < n; k++) begin
            check("busy_stall", stall, 1'b1);
            check("busy_valid", valid, 1'b0);
            tick();
        end
        modelAccess(isVec, isWr, addr, sd, vd);
        checkOutputs("done", 1'b0, 1'b1);
        tick();
        check("valid_pulse_end", valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ialuRes = '0; iswaRes = '0; vswaRes = '0;
        idleInputs();
        refScal = '0; refVec = '0;
        tick(); tick();
        checkOutputs("reset", 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Bring the whole memory to known contents.
        for (int i = 0; i < ML / VS; i++) access(1'b1, 1'b1, i * VS, '0, {$urandom, $urandom});
        checkMemAll("fill_mem");

        // Scalar store then load.
        access(1'b0, 1'b1, 5, 16'hBEEF, '0);
        check("beef_mem5", dut.r_mem[5], 8'hEF);
        check("beef_mem6", dut.r_mem[6], 8'hBE);
        access(1'b0, 1'b0, 5, '0, '0);
        check("beef_load", memData, 16'hBEEF);

        // Vector wrap-around.
        access(1'b1, 1'b1, 62, '0, 64'h0807060504030201);
        check("wrap_mem63", dut.r_mem[63], 8'h02);
        check("wrap_mem0", dut.r_mem[0], 8'h03);
        access(1'b1, 1'b0, 62, '0, '0);
        check("wrap_load", vmemData, 64'h0807060504030201);

        // Illegal request: both flags set.
        enableMem = 1'b1; flagMemRead = 1'b1; flagMemWrite = 1'b1; vecOp = 1'b1;
        ialuRes = 16'd9; vswaRes = {$urandom, $urandom};
        tick();
        idleInputs();
        check("illegal_err", err, 1'b1);
        check("illegal_stall", stall, 1'b0);
        check("illegal_valid", valid, 1'b0);
        tick();
        check("illegal_err_pulse", err, 1'b0);
        check("illegal_stall2", stall, 1'b0);
        check("illegal_valid2", valid, 1'b0);
        checkMemAll("illegal_mem");

        // No-mem passthrough.
        enableMem = 1'b0; flagMemWrite = 1'b1; ialuRes = 16'd3; iswaRes = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutputs("nomem", 1'b0, 1'b0);
        end
        idleInputs();
        checkMemAll("nomem_mem");

        // Second request during ACCESS/DONE is ignored.
        enableMem = 1'b1; flagMemRead = 1'b1; vecOp = 1'b0; ialuRes = 16'd5;
        tick();
        vecOp = 1'b1; ialuRes = 16'd40;
        check("busy2_stall1", stall, 1'b1);
        tick();
        check("busy2_stall2", stall, 1'b1);
        check("busy2_valid2", valid, 1'b0);
        tick();
        modelAccess(1'b0, 1'b0, 5, '0, '0);
        checkOutputs("busy2_done", 1'b0, 1'b1);
        idleInputs();
        tick();
        checkOutputs("busy2_idle", 1'b0, 1'b0);
        tick();
        checkOutputs("busy2_idle2", 1'b0, 1'b0);
        access(1'b1, 1'b0, 40, '0, '0);

        // Reset in the middle of a vector store.
        enableMem = 1'b1; flagMemWrite = 1'b1; vecOp = 1'b1; ialuRes = 16'd0;
        vswaRes = 64'h1122334455667788;
        tick();
        idleInputs();
        tick(); tick(); tick();
        check("rstmid_stall", stall, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        refMem[0] = 8'h88; refMem[1] = 8'h77; refMem[2] = 8'h66;
        refScal = '0; refVec = '0;
        checkOutputs("rstmid", 1'b0, 1'b0);
        checkMemAll("rstmid_mem");
        tick();
        checkOutputs("rstmid_idle", 1'b0, 1'b0);
        access(1'b1, 1'b0, 0, '0, '0);

        // Random traffic, addresses use the full register width.
        for (int i = 0; i < 30; i++) begin
            access(1'($urandom), 1'($urandom), int'($urandom_range(0, 65535)),
                   RS'($urandom), {$urandom, $urandom});
        end
        checkMemAll("random_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
